l2_memory: RTL
==============

Name: l2_memory

Overview:
- Backing-store model that sits directly downstream of the data cache on its L2 port.
- Accepts one word-sized read or write request at a time and returns the word, or acknowledges the write, after a programmable latency.
- Gives the cache line-fill (and later write-back) traffic a realistic multi-cycle partner for simulation and FPGA bring-up.

Parameters:
- XLEN, 32: address/data width in bits.
- MEM_SIZE, 4096: storage in bytes; power of two, at least 4.
- LINE_SIZE, 32: cache line size in bytes; used only by the optional burst feature.
- ACCESS_LATENCY, 4: cycles from request capture to response; must be at least 1.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- l2_address, input, XLEN: byte address; bits [1:0] ignored.
- l2_access, input, 1: request valid; level, held by the requester until l2_word_valid.
- l2_write, input, 1: 1 = write l2_wdata, 0 = read.
- l2_wdata, input, XLEN: write data.
- l2_word, output, XLEN: read data, or echo of the written data on a write.
- l2_word_valid, output, 1: one-cycle response strobe.

Behaviour:
- Reset: state IDLE, l2_word = 0, l2_word_valid = 0, counter = 0. Array contents are not touched by reset; they are zero at time 0.
- Index = l2_address[$clog2(MEM_SIZE)-1:2]. Upper address bits are ignored, so addresses wrap modulo MEM_SIZE.
- IDLE: if l2_access = 1, latch address, write and wdata, load counter with ACCESS_LATENCY-1, go to WAIT.
- WAIT: if counter = 0, go to RESPOND; otherwise decrement the counter.
- On the WAIT -> RESPOND edge:
  - Read: l2_word <= array[index].
  - Write: array[index] <= wdata and l2_word <= wdata.
- RESPOND: l2_word_valid = 1 for exactly this cycle. Next state is always IDLE.
- l2_word holds its value until the next response.
- Timing: capture at edge 0, l2_word_valid high during cycle ACCESS_LATENCY. Back-to-back request period is ACCESS_LATENCY+2 cycles.
  - The mandatory IDLE cycle lets the requester change l2_address on the edge after l2_word_valid before the next capture.
- Inputs are sampled only in IDLE. Changes to l2_address, l2_write or l2_wdata during WAIT or RESPOND are ignored.
- Dropping l2_access mid-request does not abort it; the response still pulses.
- Reset during WAIT or RESPOND: return to IDLE immediately, no l2_word_valid pulse. A pending write is discarded (array unchanged). A write whose array update already happened on the WAIT -> RESPOND edge stays committed.

Optional Feature:
- Macro: L2_MEM_BURST_EN.
- Defined:
  - A line tracker register holds the line address (address[XLEN-1:$clog2(LINE_SIZE)]) of the last completed read, plus a valid bit.
  - Valid bit is cleared by reset and by any write.
  - A read captured in IDLE that hits the tracked line loads the counter with 0, giving response latency 1.
  - Misses, and all writes, use ACCESS_LATENCY.
  - The tracker updates on every read's RESPOND cycle.
- Undefined: tracker logic is absent; every access takes ACCESS_LATENCY.

Decomposition:
- xentry_pkg additions:
  - typedef enum l2_mem_state_e {L2_IDLE, L2_WAIT, L2_RESPOND}.
  - localparam L2_WORD_BYTES = XLEN/8.
- Sub-module l2_mem_array:
  - Single-port synchronous RAM, MEM_SIZE/4 words by XLEN.
  - Inputs: we, index, wdata. Output: registered rdata.
  - Zero-initialised.
- The FSM, counter and optional burst tracker stay in l2_memory.

Test Plan:
- Reset then read: l2_access=1, l2_address=0x10, l2_write=0, ACCESS_LATENCY=4 -> l2_word_valid high only in cycle 4 after capture, l2_word = 0x0.
- Write then read: write 0xDEADBEEF to 0x20 -> ack pulse with l2_word = 0xDEADBEEF; then read 0x22 -> 0xDEADBEEF (low bits ignored).
- Wrap: write 0x12345678 to 0x1004 with MEM_SIZE=4096 -> read of 0x0004 returns 0x12345678.
- Back-to-back fill: requester holds access and steps 0x40, 0x44, ..., 0x5C on each valid -> eight pulses, spaced exactly 6 cycles apart (latency 4), correct data in each.
- Reset mid-WAIT: write 0xA5A5A5A5 to 0x30, assert reset 2 cycles after capture -> no valid pulse; a later read of 0x30 returns the previous value.
- With L2_MEM_BURST_EN: read 0x80 (latency 4) then 0x84 -> 0x84 answered with valid 1 cycle after capture; a write to 0x84 then a read of 0x88 -> latency 4.

Source files
------------

// File: rtl/l2_memory_pkg.sv
// Shared types and constants for the L2 backing-store model.
package l2_memory_pkg;

  localparam int L2_XLEN       = 32;
  localparam int L2_WORD_BYTES = L2_XLEN / 8;

  typedef enum logic [1:0] {
    L2_IDLE    = 2'd0,
    L2_WAIT    = 2'd1,
    L2_RESPOND = 2'd2
  } l2_mem_state_e;

  // Word-index width; a one-word store still needs a 1-bit index port.
  function automatic int l2_idx_width(input int mem_size);
    return ($clog2(mem_size) > 2) ? ($clog2(mem_size) - 2) : 1;
  endfunction

endpackage

// File: rtl/l2_mem_array.sv
// Single-port synchronous word RAM, zero at time 0, registered read-first output.
module l2_mem_array
  import l2_memory_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] index,
  input  logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata
);

  logic [XLEN-1:0] mem_r [DEPTH] = '{default: {XLEN{1'b0}}};

  // Storage write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[index] <= wdata;
    end
    rdata <= mem_r[index];
  end

endmodule

// File: rtl/l2_memory.sv
// L2 backing-store model: one word request at a time, fixed-latency response.
// Optional line tracker for single-cycle same-line reads: define L2_MEM_BURST_EN.
module l2_memory
  import l2_memory_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int MEM_SIZE       = 4096,
  parameter int LINE_SIZE      = 32,
  parameter int ACCESS_LATENCY = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] l2_address,
  input  logic            l2_access,
  input  logic            l2_write,
  input  logic [XLEN-1:0] l2_wdata,
  output logic [XLEN-1:0] l2_word,
  output logic            l2_word_valid
);

  localparam int AW    = $clog2(MEM_SIZE);
  localparam int DEPTH = MEM_SIZE / L2_WORD_BYTES;
  localparam int IDX_W = l2_idx_width(MEM_SIZE);
  localparam int CNT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  if ((ACCESS_LATENCY < 1) || (MEM_SIZE < 4) || ((MEM_SIZE & (MEM_SIZE - 1)) != 0) ||
      (LINE_SIZE < L2_WORD_BYTES)) begin : g_bad_cfg
    $error("l2_memory: invalid parameter set");
  end

  l2_mem_state_e    state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [IDX_W-1:0] idx_r;
  logic             write_r;
  logic [XLEN-1:0]  wdata_r;
  logic [XLEN-1:0]  word_r;
  logic             valid_r;
  logic             capture_s;
  logic             respond_s;
  logic             mem_we_s;
  logic             burst_hit_s;
  logic [IDX_W-1:0] req_idx_s;
  logic [IDX_W-1:0] mem_idx_s;
  logic [XLEN-1:0]  mem_rdata_s;
  logic             unused_addr_s;

  if (AW > 2) begin : g_idx
    assign req_idx_s = l2_address[AW-1:2];
  end else begin : g_idx_one
    assign req_idx_s = {IDX_W{1'b0}};
  end

  // Upper address bits wrap away and the byte offset is ignored.
  assign unused_addr_s = ^l2_address;

  // In IDLE the RAM looks at the live request so its word is ready by the response edge.
  assign mem_idx_s = (state_r == L2_IDLE) ? req_idx_s : idx_r;

  l2_mem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we_s),
    .index (mem_idx_s),
    .wdata (wdata_r),
    .rdata (mem_rdata_s)
  );

`ifdef L2_MEM_BURST_EN
  localparam int LINE_LSB = $clog2(LINE_SIZE);

  logic [XLEN-LINE_LSB-1:0] line_r;
  logic [XLEN-LINE_LSB-1:0] cap_line_r;
  logic                     line_valid_r;

  assign burst_hit_s = line_valid_r && !l2_write && (l2_address[XLEN-1:LINE_LSB] == line_r);

  // Last-read line tracker; any write invalidates it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_r       <= {(XLEN-LINE_LSB){1'b0}};
      cap_line_r   <= {(XLEN-LINE_LSB){1'b0}};
      line_valid_r <= 1'b0;
    end else begin
      if (capture_s) begin
        cap_line_r <= l2_address[XLEN-1:LINE_LSB];
      end
      if (state_r == L2_RESPOND) begin
        if (write_r) begin
          line_valid_r <= 1'b0;
        end else begin
          line_r       <= cap_line_r;
          line_valid_r <= 1'b1;
        end
      end
    end
  end
`else
  assign burst_hit_s = 1'b0;
`endif

  // Next-state, counter and RAM write-enable decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    respond_s = 1'b0;
    mem_we_s  = 1'b0;
    case (state_r)
      L2_IDLE: begin
        if (l2_access) begin
          capture_s = 1'b1;
          cnt_s     = burst_hit_s ? CNT_ZERO : CNT_LOAD;
          state_s   = L2_WAIT;
        end else begin
          state_s = L2_IDLE;
        end
      end
      L2_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          respond_s = 1'b1;
          mem_we_s  = write_r;
          state_s   = L2_RESPOND;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      L2_RESPOND: begin
        state_s = L2_IDLE;
      end
      default: begin
        state_s = L2_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, request latch and registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= L2_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= {IDX_W{1'b0}};
      write_r <= 1'b0;
      wdata_r <= {XLEN{1'b0}};
      word_r  <= {XLEN{1'b0}};
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      valid_r <= respond_s;
      if (capture_s) begin
        idx_r   <= req_idx_s;
        write_r <= l2_write;
        wdata_r <= l2_wdata;
      end
      if (respond_s) begin
        word_r <= write_r ? wdata_r : mem_rdata_s;
      end
    end
  end

  assign l2_word       = word_r;
  assign l2_word_valid = valid_r;

endmodule
